// File: rtl/tube_scan.sv
`default_nettype none
// ============================================================================
// Module      : tube_scan
// Description : Bus-mapped 8-digit seven-segment scanner with data/control
//               registers, per-digit blank and decimal-point masks.
// Revision    : 1.0 - initial release
// ============================================================================
module tube_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] Addr,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic [7:0]  Seg,
    output logic [7:0]  Sel
);

    localparam int         c_PRE_W   = 20;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(SCAN_DIV - 1);

    logic [31:0]        r_data;
    logic               r_en;
    logic [7:0]         r_blank;
    logic [7:0]         r_dp;
    logic [c_PRE_W-1:0] r_pre;
    logic [2:0]         r_idx;

    logic               w_wr_data;
    logic               w_wr_ctrl;
    logic               w_en_next;
    logic               w_tick;
    logic [c_PRE_W-1:0] w_pre_next;
    logic [2:0]         w_idx_next;
    logic [3:0]         w_nib;
    logic [6:0]         w_hex;
    logic               w_lit;
    logic [7:0]         w_sel_next;
    logic [7:0]         w_seg_next;
    logic               w_unused;

    assign w_unused  = ^{Addr[31:3], Addr[1:0]};

    assign w_wr_data = WE & ~Addr[2];
    assign w_wr_ctrl = WE &  Addr[2];
    assign w_en_next = w_wr_ctrl ? DIn[0] : r_en;
    assign w_tick    = r_en && (r_pre == c_PRE_MAX);

    // Disabling (even on a tick edge) or re-enabling restarts at digit 0.
    always_comb begin
        w_pre_next = '0;
        w_idx_next = '0;
        if (w_en_next && r_en) begin
            if (w_tick) begin
                w_pre_next = '0;
                w_idx_next = r_idx + 3'd1;
            end else begin
                w_pre_next = r_pre + c_PRE_W'(1);
                w_idx_next = r_idx;
            end
        end
    end

    assign w_nib = r_data[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_hex = 7'h7F;
        case (w_nib)
            4'h0: w_hex = 7'h40;
            4'h1: w_hex = 7'h79;
            4'h2: w_hex = 7'h24;
            4'h3: w_hex = 7'h30;
            4'h4: w_hex = 7'h19;
            4'h5: w_hex = 7'h12;
            4'h6: w_hex = 7'h02;
            4'h7: w_hex = 7'h78;
            4'h8: w_hex = 7'h00;
            4'h9: w_hex = 7'h10;
            4'hA: w_hex = 7'h08;
            4'hB: w_hex = 7'h03;
            4'hC: w_hex = 7'h46;
            4'hD: w_hex = 7'h21;
            4'hE: w_hex = 7'h06;
            4'hF: w_hex = 7'h0E;
            default: w_hex = 7'h7F;
        endcase
    end

    assign w_lit      = r_en & ~r_blank[r_idx];
    assign w_sel_next = w_lit ? ~(8'd1 << r_idx) : 8'hFF;
    assign w_seg_next = w_lit ? {~r_dp[r_idx], w_hex} : 8'hFF;

    assign DOut = Addr[2] ? {8'h00, r_dp, r_blank, 7'h00, r_en} : r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_en    <= 1'b1;
            r_blank <= '0;
            r_dp    <= '0;
            r_pre   <= '0;
            r_idx   <= '0;
            Seg     <= 8'hFF;
            Sel     <= 8'hFF;
        end else begin
            if (w_wr_data) begin
                r_data <= DIn;
            end
            if (w_wr_ctrl) begin
                r_en    <= DIn[0];
                r_blank <= DIn[15:8];
                r_dp    <= DIn[23:16];
            end
            r_pre <= w_pre_next;
            r_idx <= w_idx_next;
            Seg   <= w_seg_next;
            Sel   <= w_sel_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tube_scan.sv
`default_nettype none
// Testbench for tube_scan: random and directed bus traffic against a
// time-based model of the scanned display (two scan dividers in parallel).
module tb_tube_scan;

    localparam int DIV_A = 4;
    localparam int DIV_B = 1;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [31:0] Addr;
    logic [31:0] DIn;
    logic [31:0] dout_a, dout_b;
    logic [7:0]  seg_a, sel_a, seg_b, sel_b;

    tube_scan #(.SCAN_DIV(DIV_A)) dut_a (
        .clk(clk), .reset(reset), .WE(WE), .Addr(Addr), .DIn(DIn),
        .DOut(dout_a), .Seg(seg_a), .Sel(sel_a)
    );

    tube_scan #(.SCAN_DIV(DIV_B)) dut_b (
        .clk(clk), .reset(reset), .WE(WE), .Addr(Addr), .DIn(DIn),
        .DOut(dout_b), .Seg(seg_b), .Sel(sel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: register contents plus cycles elapsed since scan start.
    logic [31:0] m_data;
    logic [31:0] m_ctrl;
    int          m_ta;
    int          m_tb;

    logic [7:0] hex_tab [16];
    initial begin
        hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_data = 32'h0;
        m_ctrl = 32'h1;
        m_ta   = 0;
        m_tb   = 0;
    endfunction

    function automatic void model_out(input int t, input int div,
                                      output logic [7:0] esel, output logic [7:0] eseg);
        int d;
        d = (t / div) % 8;
        if (!m_ctrl[0] || m_ctrl[8 + d]) begin
            esel = 8'hFF;
            eseg = 8'hFF;
        end else begin
            esel = 8'hFF;
            esel[d] = 1'b0;
            eseg = hex_tab[m_data[4*d +: 4]];
            eseg[7] = ~m_ctrl[16 + d];
        end
    endfunction

    function automatic void model_step(input bit we, input bit a2, input logic [31:0] d);
        bit old_en;
        old_en = m_ctrl[0];
        if (we) begin
            if (a2) m_ctrl = d & 32'h00FF_FF01;
            else    m_data = d;
        end
        if (!m_ctrl[0] || !old_en) begin
            m_ta = 0;
            m_tb = 0;
        end else begin
            m_ta = (m_ta + 1) % (8 * DIV_A);
            m_tb = (m_tb + 1) % (8 * DIV_B);
        end
    endfunction

    function automatic int digit_a();
        return (m_ta / DIV_A) % 8;
    endfunction

    // One clock: drive inputs, predict from pre-edge state, compare after edge.
    task automatic cycle(input bit we, input bit a2, input logic [31:0] d);
        logic [7:0] esel_a, eseg_a, esel_b, eseg_b;
        WE   = we;
        Addr = {29'h0, a2, 2'b00};
        DIn  = d;
        model_out(m_ta, DIV_A, esel_a, eseg_a);
        model_out(m_tb, DIV_B, esel_b, eseg_b);
        model_step(we, a2, d);
        @(posedge clk);
        #1;
        check("sel_a", {24'h0, sel_a}, {24'h0, esel_a});
        check("seg_a", {24'h0, seg_a}, {24'h0, eseg_a});
        check("sel_b", {24'h0, sel_b}, {24'h0, esel_b});
        check("seg_b", {24'h0, seg_b}, {24'h0, eseg_b});
        check("dout_a", dout_a, a2 ? m_ctrl : m_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, i[0], 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = 32'h0;
        DIn   = 32'h0;
        model_reset();
        #3;
        check("rst_sel", {24'h0, sel_a}, 32'hFF);
        check("rst_seg", {24'h0, seg_a}, 32'hFF);
        check("rst_data", dout_a, 32'h0);
        Addr = 32'h4;
        #1;
        check("rst_ctrl", dout_a, 32'h1);
        #18;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first_sel", {24'h0, sel_a}, 32'hFE);
        check("first_seg", {24'h0, seg_a}, 32'hC0);
        model_step(1'b0, 1'b0, 32'h0);
        idle(40);

        cycle(1'b1, 1'b0, 32'h89AB_CDEF);
        idle(36);
        Addr = 32'h0;
        #1;
        check("rd_data", dout_a, 32'h89AB_CDEF);

        cycle(1'b1, 1'b1, 32'h0001_0201);
        idle(40);
        WE = 1'b0; Addr = 32'h4; DIn = 32'hFFFF_FFFF;
        #1;
        check("rd_ctrl", dout_a, 32'h0001_0201);

        cycle(1'b1, 1'b1, 32'h1);
        for (int i = 0; i < 40 && digit_a() != 5; i++) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0);
        idle(3);
        cycle(1'b1, 1'b1, 32'h1);
        idle(12);

        for (int i = 0; i < 40 && digit_a() != 3; i++) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        #3;
        reset = 1'b1;
        Addr  = 32'h0;
        #1;
        check("arst_sel", {24'h0, sel_a}, 32'hFF);
        check("arst_seg", {24'h0, seg_a}, 32'hFF);
        check("arst_dout", dout_a, 32'h0);
        model_reset();
        WE = 1'b1; DIn = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        WE = 1'b0;
        check("rst_wr_ign", dout_a, 32'h0);
        #3;
        reset = 1'b0;
        idle(40);

        for (int i = 0; i < 1500; i++) begin
            bit          we, a2;
            logic [31:0] d;
            we = ($urandom_range(0, 9) == 0);
            a2 = $urandom_range(0, 1) == 1;
            d  = $urandom;
            if (a2 && $urandom_range(0, 7) != 0) d[0] = 1'b1;
            cycle(we, a2, d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
